// File: rtl/serializer_pkg.sv
//------------------------------------------------------------------------------
// Module  : serializer_pkg
// Brief   : Shared state encoding and sizing helper for the serializer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serializer_pkg;

  localparam int unsigned c_STATE_W = 1;

  typedef logic [c_STATE_W-1:0] state_t;

  localparam state_t c_ST_IDLE  = 1'b0;
  localparam state_t c_ST_SHIFT = 1'b1;

  // Bit-counter width for a given word width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serializer_bit_counter.sv
//------------------------------------------------------------------------------
// Module  : bit_counter
// Brief   : Loadable down-counter that saturates at zero, with a zero flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bit_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;
  logic             w_zero;

  assign w_zero = (r_count == '0);
  assign o_zero = w_zero;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && !w_zero) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serializer.sv
//------------------------------------------------------------------------------
// Module  : serializer
// Brief   : Parallel-to-serial converter with valid/ready load, shift enable
//           and zero-bubble back-to-back words.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  input  logic             VALID,
  output logic             READY,
  input  logic             SEN,
  output logic             SO,
  output logic             SVALID,
  output logic             LAST
);

  localparam int unsigned        c_CNT_W    = cnt_width(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LOAD_VAL = c_CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_shifted;
  logic             w_out_bit;
  logic             w_cnt_zero;
  logic             w_accept;
  logic             w_advance;

  assign w_accept  = VALID && READY;
  assign w_advance = (r_state == c_ST_SHIFT) && SEN;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_out_bit       = r_shreg[WIDTH-1];
      assign w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_out_bit       = r_shreg[0];
      assign w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  bit_counter #(
    .CNT_W (c_CNT_W)
  ) u_bit_counter (
    .CLK          (CLK),
    .RESET        (RESET),
    .i_load       (w_accept),
    .i_load_value (c_LOAD_VAL),
    .i_dec        (w_advance),
    .o_zero       (w_cnt_zero)
  );

  // A fresh word overrides the shift so a final-bit edge can reload directly.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_shreg <= '0;
    end else if (w_accept) begin
      r_shreg <= D;
    end else if (w_advance) begin
      r_shreg <= w_shreg_shifted;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_state_next = c_ST_SHIFT;
        end
      end
      c_ST_SHIFT: begin
        if (SEN && w_cnt_zero && !w_accept) begin
          w_state_next = c_ST_IDLE;
        end
      end
      default: w_state_next = c_ST_IDLE;
    endcase
  end

  // Serial outputs depend only on state and registers; READY also sees SEN.
  always_comb begin
    READY  = 1'b0;
    SO     = 1'b0;
    SVALID = 1'b0;
    LAST   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        READY = !RESET;
      end
      c_ST_SHIFT: begin
        READY  = !RESET && w_cnt_zero && SEN;
        SO     = w_out_bit;
        SVALID = 1'b1;
        LAST   = w_cnt_zero;
      end
      default: begin
        READY = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_serializer.sv
//------------------------------------------------------------------------------
// Module  : tb_serializer
// Brief   : Directed self-checking bench for serializer (MSB- and LSB-first).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serializer;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] D     = 8'h00;
  logic       VALID = 1'b0;
  logic       SEN   = 1'b1;

  logic ready_m, so_m, svalid_m, last_m;
  logic ready_l, so_l, svalid_l, last_l;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .CLK(CLK), .RESET(RESET), .D(D), .VALID(VALID), .READY(ready_m),
    .SEN(SEN), .SO(so_m), .SVALID(svalid_m), .LAST(last_m)
  );

  serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK(CLK), .RESET(RESET), .D(D), .VALID(VALID), .READY(ready_l),
    .SEN(SEN), .SO(so_l), .SVALID(svalid_l), .LAST(last_l)
  );

  // Present a word mid-cycle; it is taken on the following rising edge.
  task automatic start_word(input logic [7:0] w);
    @(negedge CLK);
    D     = w;
    VALID = 1'b1;
    SEN   = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (ready_m !== 1'b0)  begin errors++; $display("FAIL reset_ready got %b expected 0", ready_m); end
    checks++; if (svalid_m !== 1'b0) begin errors++; $display("FAIL reset_svalid got %b expected 0", svalid_m); end
    checks++; if (so_m !== 1'b0)     begin errors++; $display("FAIL reset_so got %b expected 0", so_m); end
    checks++; if (last_m !== 1'b0)   begin errors++; $display("FAIL reset_last got %b expected 0", last_m); end
    VALID = 1'b1;
    D     = 8'hFF;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (svalid_m !== 1'b0) begin errors++; $display("FAIL reset_noaccept got %b expected 0", svalid_m); end
    @(negedge CLK);
    RESET = 1'b0;
    VALID = 1'b0;
    #1;
    checks++; if (ready_m !== 1'b1) begin errors++; $display("FAIL release_ready got %b expected 1", ready_m); end
    checks++; if (ready_l !== 1'b1) begin errors++; $display("FAIL release_ready_lsb got %b expected 1", ready_l); end
  endtask

  task automatic test_single;
    logic [7:0] w;
    w = 8'hA5;
    start_word(w);
    #1;
    checks++; if (ready_m !== 1'b1) begin errors++; $display("FAIL single_idle_ready got %b expected 1", ready_m); end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      VALID = 1'b0;
      #1;
      checks++; if (so_m !== w[7-i])          begin errors++; $display("FAIL single_so cycle %0d got %b expected %b", i, so_m, w[7-i]); end
      checks++; if (svalid_m !== 1'b1)        begin errors++; $display("FAIL single_svalid cycle %0d got %b expected 1", i, svalid_m); end
      checks++; if (last_m !== (i == 7))      begin errors++; $display("FAIL single_last cycle %0d got %b expected %b", i, last_m, (i == 7)); end
      checks++; if (ready_m !== (i == 7))     begin errors++; $display("FAIL single_ready cycle %0d got %b expected %b", i, ready_m, (i == 7)); end
    end
    @(negedge CLK);
    #1;
    checks++; if (svalid_m !== 1'b0) begin errors++; $display("FAIL single_idle_svalid got %b expected 0", svalid_m); end
    checks++; if (ready_m !== 1'b1)  begin errors++; $display("FAIL single_idle_ready2 got %b expected 1", ready_m); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w0, w1, w;
    w0 = 8'hA5;
    w1 = 8'h3C;
    start_word(w0);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (i == 0)  D = w1;
      if (i == 15) VALID = 1'b0;
      #1;
      w = (i < 8) ? w0 : w1;
      checks++; if (so_m !== w[7-(i%8)])        begin errors++; $display("FAIL b2b_so cycle %0d got %b expected %b", i, so_m, w[7-(i%8)]); end
      checks++; if (svalid_m !== 1'b1)          begin errors++; $display("FAIL b2b_svalid cycle %0d got %b expected 1", i, svalid_m); end
      checks++; if (last_m !== (i % 8 == 7))    begin errors++; $display("FAIL b2b_last cycle %0d got %b expected %b", i, last_m, (i % 8 == 7)); end
      checks++; if (ready_m !== (i % 8 == 7))   begin errors++; $display("FAIL b2b_ready cycle %0d got %b expected %b", i, ready_m, (i % 8 == 7)); end
    end
    @(negedge CLK);
    #1;
    checks++; if (svalid_m !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b expected 0", svalid_m); end
  endtask

  task automatic test_stall;
    logic [10:0] so_exp;
    logic        sen_v;
    so_exp = 11'b101_0000_0101;
    start_word(8'hA5);
    for (int c = 0; c < 11; c++) begin
      @(negedge CLK);
      VALID = 1'b0;
      sen_v = !(c >= 3 && c <= 5);
      SEN   = sen_v;
      #1;
      checks++; if (so_m !== so_exp[10-c])    begin errors++; $display("FAIL stall_so cycle %0d got %b expected %b", c, so_m, so_exp[10-c]); end
      checks++; if (svalid_m !== 1'b1)        begin errors++; $display("FAIL stall_svalid cycle %0d got %b expected 1", c, svalid_m); end
      checks++; if (last_m !== (c == 10))     begin errors++; $display("FAIL stall_last cycle %0d got %b expected %b", c, last_m, (c == 10)); end
      checks++; if (ready_m !== (c == 10))    begin errors++; $display("FAIL stall_ready cycle %0d got %b expected %b", c, ready_m, (c == 10)); end
    end
    @(negedge CLK);
    SEN = 1'b1;
    #1;
    checks++; if (svalid_m !== 1'b0) begin errors++; $display("FAIL stall_idle got %b expected 0", svalid_m); end
  endtask

  task automatic test_lsb_first;
    start_word(8'h01);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      VALID = 1'b0;
      #1;
      checks++; if (so_l !== (i == 0))     begin errors++; $display("FAIL lsb_so cycle %0d got %b expected %b", i, so_l, (i == 0)); end
      checks++; if (svalid_l !== 1'b1)     begin errors++; $display("FAIL lsb_svalid cycle %0d got %b expected 1", i, svalid_l); end
      checks++; if (last_l !== (i == 7))   begin errors++; $display("FAIL lsb_last cycle %0d got %b expected %b", i, last_l, (i == 7)); end
      checks++; if (so_m !== (i == 7))     begin errors++; $display("FAIL lsb_msbref_so cycle %0d got %b expected %b", i, so_m, (i == 7)); end
    end
    @(negedge CLK);
    #1;
    checks++; if (svalid_l !== 1'b0) begin errors++; $display("FAIL lsb_idle got %b expected 0", svalid_l); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] w;
    w = 8'hA5;
    start_word(w);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      VALID = 1'b0;
      #1;
      checks++; if (so_m !== w[7-i]) begin errors++; $display("FAIL rstmid_so cycle %0d got %b expected %b", i, so_m, w[7-i]); end
    end
    RESET = 1'b1;
    #1;
    checks++; if (svalid_m !== 1'b0) begin errors++; $display("FAIL rstmid_svalid got %b expected 0", svalid_m); end
    checks++; if (so_m !== 1'b0)     begin errors++; $display("FAIL rstmid_so_clear got %b expected 0", so_m); end
    checks++; if (last_m !== 1'b0)   begin errors++; $display("FAIL rstmid_last got %b expected 0", last_m); end
    checks++; if (ready_m !== 1'b0)  begin errors++; $display("FAIL rstmid_ready got %b expected 0", ready_m); end
    @(negedge CLK);
    #1;
    checks++; if (svalid_m !== 1'b0) begin errors++; $display("FAIL rstmid_hold got %b expected 0", svalid_m); end
    @(negedge CLK);
    RESET = 1'b0;
    D     = 8'hFF;
    VALID = 1'b1;
    #1;
    checks++; if (ready_m !== 1'b1) begin errors++; $display("FAIL rstmid_release_ready got %b expected 1", ready_m); end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      VALID = 1'b0;
      #1;
      checks++; if (so_m !== 1'b1)        begin errors++; $display("FAIL rstmid_ff_so cycle %0d got %b expected 1", i, so_m); end
      checks++; if (last_m !== (i == 7))  begin errors++; $display("FAIL rstmid_ff_last cycle %0d got %b expected %b", i, last_m, (i == 7)); end
    end
    @(negedge CLK);
    #1;
    checks++; if (svalid_m !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b expected 0", svalid_m); end
  endtask

  task automatic test_ignore_busy;
    logic [7:0] w;
    w = 8'hA5;
    start_word(w);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      VALID = (i <= 6);
      D     = 8'h00;
      #1;
      checks++; if (so_m !== w[7-i])       begin errors++; $display("FAIL busy_so cycle %0d got %b expected %b", i, so_m, w[7-i]); end
      checks++; if (ready_m !== (i == 7))  begin errors++; $display("FAIL busy_ready cycle %0d got %b expected %b", i, ready_m, (i == 7)); end
    end
    @(negedge CLK);
    #1;
    checks++; if (svalid_m !== 1'b0) begin errors++; $display("FAIL busy_idle got %b expected 0", svalid_m); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_lsb_first();
    test_reset_mid();
    test_ignore_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1, bit order; 1 = D[WIDTH-1] first, 0 = D[0] first.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 D  input  WIDTH  parallel word to transmit.
REQ-006 VALID  input  1  D holds a word to load.
REQ-007 READY  output  1  serializer accepts a word this cycle.
REQ-008 SEN  input  1  shift enable; 0 stalls the serial stream.
REQ-009 SO  output  1  serial data bit.
REQ-010 SVALID  output  1  SO carries a valid bit.
REQ-011 LAST  output  1  SO carries the final bit of the current word.

Function
REQ-012 Two states SHALL exist: IDLE and SHIFT.
REQ-013 A word SHALL be accepted on a rising CLK edge where VALID=1 and READY=1; D SHALL be captured into the shift register at that edge.
REQ-014 IDLE: READY=1, SVALID=0, LAST=0, SO=0; an accept SHALL move to SHIFT with bit counter = WIDTH-1.
REQ-015 Latency: the first bit SHALL appear on SO with SVALID=1 in the cycle immediately after the accepting edge.
REQ-016 SHIFT: SO = shift-register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0); SVALID=1.
REQ-017 SHIFT with SEN=1: each edge SHALL advance one bit and decrement the counter; SEN=0: shift register, counter, SO, LAST SHALL hold.
REQ-018 LAST SHALL be 1 exactly when in SHIFT with counter = 0.
REQ-019 READY SHALL be 1 in SHIFT only when counter = 0 and SEN = 1 (final bit consumed this edge); otherwise 0 in SHIFT.
REQ-020 Final-bit edge with accept: SHALL reload from D, counter = WIDTH-1, stay in SHIFT (zero-bubble back-to-back).
REQ-021 Final-bit edge without accept: SHALL return to IDLE.
REQ-022 VALID while READY=0 SHALL be ignored; D changes while busy SHALL not affect the stream.
REQ-023 SO, SVALID, LAST SHALL be driven from registers only (no combinational path from D, VALID, SEN); READY MAY depend combinationally on SEN.
REQ-024 Counter width SHALL be clog2(WIDTH); no wrap below 0.

Reset
REQ-025 RESET=1 SHALL immediately force IDLE, shift register = 0, counter = 0, SO=0, SVALID=0, LAST=0, READY=0.
REQ-026 Reset mid-word SHALL abort the word; no remaining bits SHALL be emitted.
REQ-027 READY SHALL rise combinationally once RESET deasserts; first accept possible on the first edge after deassertion.

Structure
REQ-028 State encoding constants (IDLE=0, SHIFT=1) SHALL live in the shared package serializer_pkg.
REQ-029 The down-counter with zero flag SHALL be a sub-module named bit_counter; shift register and FSM SHALL stay inline.

Verification
REQ-030 WIDTH=8, MSB_FIRST=1, SEN=1, D=8'hA5 accepted -> SO=1,0,1,0,0,1,0,1 on 8 consecutive cycles, SVALID=1 throughout, LAST only on 8th, then IDLE.
REQ-031 Back-to-back 8'hA5 then 8'h3C with VALID held -> 16 contiguous SVALID cycles, LAST on cycles 8 and 16, READY pulses on cycle 8.
REQ-032 SEN=0 for 3 cycles after 4th bit of 8'hA5 -> SO holds 0 (bit 4) for 4 cycles total, stream resumes with 0,1,0,1.
REQ-033 MSB_FIRST=0, D=8'h01 -> SO=1 then seven 0s; LAST on 8th.
REQ-034 RESET asserted during 3rd bit -> SVALID=0 and SO=0 immediately, no further bits; after release, 8'hFF accepted -> eight 1s.
REQ-035 VALID=1 with D=8'h00 during busy SHIFT (counter>0) -> ignored; stream of current word unaltered.
